// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
//
// Main control FSM for the multi-cycle LEGv8 datapath. It walks the shared
// datapath (PC, IR, register file, single memory port, ALU) through
// fetch / decode / execute / memory / writeback. It also drives ALUOp into
// the existing ALU control decoder. A watchdog stops the machine when memory
// never answers. The machine halts for good on an unknown opcode.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous, active-high reset
//   opcode     - instruction[31:21] from the IR
//   zero       - ALU zero flag (CBZ condition)
//   mem_ready  - memory completes the current read/write this cycle
//   mem_read   - memory read strobe
//   mem_write  - memory write strobe
//   i_or_d     - memory address select: 0=PC, 1=ALUOut
//   ir_write   - IR load enable
//   pc_en      - PC load enable
//   pc_source  - 00=ALU result, 01=ALUOut, 10=branch target
//   reg_write  - register file write enable
//   mem_to_reg - writeback select: 0=ALUOut, 1=MDR
//   reg2loc    - read-register-2 select: 1=Rt[4:0]
//   alu_src_a  - 0=PC, 1=reg A
//   alu_src_b  - 00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext offset<<2
//   ALUOp0     - ALU op low bit
//   ALUOp1     - ALU op high bit
//   illegal_op - sticky, unknown opcode decoded
//   bus_error  - sticky, memory wait timeout
//   state      - current state encoding, for debug
// ----------------------------------------------------------------------------
module multicycle_control #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_read,
    output logic        mem_write,
    output logic        i_or_d,
    output logic        ir_write,
    output logic        pc_en,
    output logic [1:0]  pc_source,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        reg2loc,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        ALUOp0,
    output logic        ALUOp1,
    output logic        illegal_op,
    output logic        bus_error,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC_R = 4'd2,
        ADDR   = 4'd3,
        MEM_RD = 4'd4,
        WB_LD  = 4'd5,
        MEM_WR = 4'd6,
        WB_R   = 4'd7,
        CBZ    = 4'd8,
        BRANCH = 4'd9,
        HALT   = 4'd15
    } stateT;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    // The last counter value at which a missing mem_ready is still tolerated.
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MAX_WAIT - 1);

    stateT             r_state;
    stateT             w_nextState;
    logic [WAIT_W-1:0] r_waitCount;
    logic              r_illegalOp;
    logic              r_busError;

    logic              w_setIllegal;
    logic              w_setBusError;
    logic              w_isWaitState;
    logic              w_timeout;
    logic              w_isRType;
    logic              w_isCbz;
    logic              w_isB;

    logic              w_memRead;
    logic              w_memWrite;
    logic              w_irWrite;
    logic              w_pcEn;
    logic              w_regWrite;

    // Opcode classes. CBZ and B match only on their prefix bits because the
    // rest of instruction[31:21] holds immediate/offset bits.
    always_comb begin
        w_isRType = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                    (opcode == OP_AND) || (opcode == OP_ORR);
        w_isCbz   = (opcode[10:3] == 8'b10110100);
        w_isB     = (opcode[10:5] == 6'b000101);
    end

    // The watchdog only runs in the three states that wait on memory. It
    // trips on the cycle where mem_ready is still low and the counter already
    // sits at its last allowed value.
    always_comb begin
        w_isWaitState = (r_state == FETCH) || (r_state == MEM_RD) ||
                        (r_state == MEM_WR);
        w_timeout     = w_isWaitState && !mem_ready && (r_waitCount == LAST_WAIT);
    end

    // Next-state and output decode. The outputs are mostly Moore. The
    // exceptions are the FETCH handshake strobes (ir_write/pc_en follow
    // mem_ready) and the CBZ pc_en (follows zero). Every output starts at 0,
    // so each state lists only what it asserts.
    always_comb begin
        w_nextState   = r_state;
        w_setIllegal  = 1'b0;
        w_setBusError = 1'b0;
        w_memRead     = 1'b0;
        w_memWrite    = 1'b0;
        w_irWrite     = 1'b0;
        w_pcEn        = 1'b0;
        w_regWrite    = 1'b0;
        i_or_d        = 1'b0;
        pc_source     = 2'b00;
        mem_to_reg    = 1'b0;
        reg2loc       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        ALUOp0        = 1'b0;
        ALUOp1        = 1'b0;

        case (r_state)
            FETCH: begin
                w_memRead = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    w_irWrite   = 1'b1;
                    w_pcEn      = 1'b1;
                    w_nextState = DECODE;
                end else if (w_timeout) begin
                    w_setBusError = 1'b1;
                    w_nextState   = HALT;
                end
            end
            DECODE: begin
                // The ALU computes the branch target into ALUOut speculatively.
                alu_src_b = 2'b11;
                reg2loc   = (opcode == OP_STUR) || w_isCbz;
                if (w_isRType) begin
                    w_nextState = EXEC_R;
                end else if ((opcode == OP_LDUR) || (opcode == OP_STUR)) begin
                    w_nextState = ADDR;
                end else if (w_isCbz) begin
                    w_nextState = CBZ;
                end else if (w_isB) begin
                    w_nextState = BRANCH;
                end else begin
                    w_setIllegal = 1'b1;
                    w_nextState  = HALT;
                end
            end
            EXEC_R: begin
                alu_src_a   = 1'b1;
                ALUOp1      = 1'b1;
                w_nextState = WB_R;
            end
            WB_R: begin
                w_regWrite  = 1'b1;
                w_nextState = FETCH;
            end
            ADDR: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                reg2loc     = 1'b1;
                w_nextState = (opcode == OP_LDUR) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                w_memRead = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    w_nextState = WB_LD;
                end else if (w_timeout) begin
                    w_setBusError = 1'b1;
                    w_nextState   = HALT;
                end
            end
            WB_LD: begin
                w_regWrite  = 1'b1;
                mem_to_reg  = 1'b1;
                w_nextState = FETCH;
            end
            MEM_WR: begin
                w_memWrite = 1'b1;
                i_or_d     = 1'b1;
                reg2loc    = 1'b1;
                if (mem_ready) begin
                    w_nextState = FETCH;
                end else if (w_timeout) begin
                    w_setBusError = 1'b1;
                    w_nextState   = HALT;
                end
            end
            CBZ: begin
                // The ALU passes B through so the datapath can generate zero.
                // The PC then loads the target held in ALUOut since DECODE.
                alu_src_a   = 1'b1;
                ALUOp0      = 1'b1;
                reg2loc     = 1'b1;
                pc_source   = 2'b01;
                w_pcEn      = zero;
                w_nextState = FETCH;
            end
            BRANCH: begin
                w_pcEn      = 1'b1;
                pc_source   = 2'b10;
                w_nextState = FETCH;
            end
            HALT: begin
                w_nextState = HALT;
            end
            default: begin
                w_nextState = HALT;
            end
        endcase
    end

    // Reset drops every strobe in the same cycle. An in-flight memory access
    // is abandoned at once and is not held until the next edge.
    always_comb begin
        mem_read  = w_memRead  & ~reset;
        mem_write = w_memWrite & ~reset;
        ir_write  = w_irWrite  & ~reset;
        pc_en     = w_pcEn     & ~reset;
        reg_write = w_regWrite & ~reset;
    end

    // State register, wait counter and sticky flags. The counter restarts on
    // every state change. It saturates instead of wrapping, so a long stall
    // can never look like a fresh one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= FETCH;
            r_waitCount <= '0;
            r_illegalOp <= 1'b0;
            r_busError  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_nextState != r_state) begin
                r_waitCount <= '0;
            end else if (w_isWaitState && !mem_ready && (r_waitCount != '1)) begin
                r_waitCount <= r_waitCount + 1'b1;
            end
            if (w_setIllegal) begin
                r_illegalOp <= 1'b1;
            end
            if (w_setBusError) begin
                r_busError <= 1'b1;
            end
        end
    end

    always_comb begin
        illegal_op = r_illegalOp;
        bus_error  = r_busError;
        state      = r_state;
    end

endmodule

// File: tb/tb_multicycle_control.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control
//
// Directed bench for multicycle_control. The DUT uses MAX_WAIT=4 so that the
// watchdog boundary is reached in a few cycles. Inputs change 1 time unit
// after the rising edge. Outputs are sampled 1 time unit after that, well
// clear of the next edge.
// ----------------------------------------------------------------------------
module tb_multicycle_control;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100101;
    localparam logic [10:0] OP_B    = 11'b00010110011;
    localparam logic [10:0] OP_BAD  = 11'b11111111111;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] opcode;
    logic        zero;
    logic        mem_ready;
    logic        mem_read;
    logic        mem_write;
    logic        i_or_d;
    logic        ir_write;
    logic        pc_en;
    logic [1:0]  pc_source;
    logic        reg_write;
    logic        mem_to_reg;
    logic        reg2loc;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        ALUOp0;
    logic        ALUOp1;
    logic        illegal_op;
    logic        bus_error;
    logic [3:0]  state;

    int compareCount = 0;
    int failCount    = 0;

    multicycle_control #(
        .MAX_WAIT (4),
        .WAIT_W   (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .i_or_d     (i_or_d),
        .ir_write   (ir_write),
        .pc_en      (pc_en),
        .pc_source  (pc_source),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .reg2loc    (reg2loc),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ALUOp0     (ALUOp0),
        .ALUOp1     (ALUOp1),
        .illegal_op (illegal_op),
        .bus_error  (bus_error),
        .state      (state)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    // Drive one set of inputs, then let the combinational outputs settle.
    task automatic applyStimulus(input logic rst, input logic [10:0] op,
                                 input logic z, input logic rdy);
        reset     = rst;
        opcode    = op;
        zero      = z;
        mem_ready = rdy;
        #1;
    endtask

    // Advance one rising edge and step just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One comparison. It counts the check and, on a mismatch, counts the
    // failure and reports it.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        compareCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // The five strobes packed as {mem_read, mem_write, ir_write, pc_en, reg_write}.
    function automatic logic [15:0] strobes();
        return {11'd0, mem_read, mem_write, ir_write, pc_en, reg_write};
    endfunction

    function automatic logic [15:0] aluOp();
        return {14'd0, ALUOp1, ALUOp0};
    endfunction

    initial begin
        // Reset, with the strobes forced low while reset is held.
        applyStimulus(1'b1, OP_ADD, 1'b0, 1'b1);
        tick();
        checkOutput("rst_state",   16'(state),      16'd0);
        checkOutput("rst_illegal", 16'(illegal_op), 16'd0);
        checkOutput("rst_buserr",  16'(bus_error),  16'd0);
        checkOutput("rst_strobes", strobes(),       16'b00000);

        // ADD with zero-wait memory: 0,1,2,7,0.
        applyStimulus(1'b0, OP_ADD, 1'b0, 1'b1);
        checkOutput("add_fetch_strobes", strobes(),        16'b10110);
        checkOutput("add_fetch_srcb",    16'(alu_src_b),   16'd1);
        checkOutput("add_fetch_iord",    16'(i_or_d),      16'd0);
        tick();
        checkOutput("add_decode_state",  16'(state),       16'd1);
        checkOutput("add_decode_strobes", strobes(),       16'b00000);
        checkOutput("add_decode_srcb",   16'(alu_src_b),   16'd3);
        checkOutput("add_decode_r2l",    16'(reg2loc),     16'd0);
        tick();
        checkOutput("add_exec_state",    16'(state),       16'd2);
        checkOutput("add_exec_aluop",    aluOp(),          16'd2);
        checkOutput("add_exec_srca",     16'(alu_src_a),   16'd1);
        checkOutput("add_exec_srcb",     16'(alu_src_b),   16'd0);
        checkOutput("add_exec_strobes",  strobes(),        16'b00000);
        tick();
        checkOutput("add_wb_state",      16'(state),       16'd7);
        checkOutput("add_wb_strobes",    strobes(),        16'b00001);
        checkOutput("add_wb_m2r",        16'(mem_to_reg),  16'd0);
        tick();
        checkOutput("add_done_state",    16'(state),       16'd0);

        // LDUR with three wait cycles in MEM_RD: 8 cycles FETCH to FETCH.
        applyStimulus(1'b0, OP_LDUR, 1'b0, 1'b1);
        tick();
        checkOutput("ld_decode_state",   16'(state),       16'd1);
        tick();
        checkOutput("ld_addr_state",     16'(state),       16'd3);
        checkOutput("ld_addr_srcb",      16'(alu_src_b),   16'd2);
        checkOutput("ld_addr_r2l",       16'(reg2loc),     16'd1);
        tick();
        applyStimulus(1'b0, OP_LDUR, 1'b0, 1'b0);
        checkOutput("ld_memrd_state",    16'(state),       16'd4);
        checkOutput("ld_memrd_strobes",  strobes(),        16'b10000);
        checkOutput("ld_memrd_iord",     16'(i_or_d),      16'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("ld_memrd_hold", 16'(state),       16'd4);
        end
        applyStimulus(1'b0, OP_LDUR, 1'b0, 1'b1);
        tick();
        checkOutput("ld_wb_state",       16'(state),       16'd5);
        checkOutput("ld_wb_strobes",     strobes(),        16'b00001);
        checkOutput("ld_wb_m2r",         16'(mem_to_reg),  16'd1);
        tick();
        checkOutput("ld_done_state",     16'(state),       16'd0);
        checkOutput("ld_done_buserr",    16'(bus_error),   16'd0);

        // CBZ taken (zero=1).
        applyStimulus(1'b0, OP_CBZ, 1'b1, 1'b1);
        tick();
        checkOutput("cbz1_decode_r2l",   16'(reg2loc),     16'd1);
        tick();
        checkOutput("cbz1_state",        16'(state),       16'd8);
        checkOutput("cbz1_aluop",        aluOp(),          16'd1);
        checkOutput("cbz1_r2l",          16'(reg2loc),     16'd1);
        checkOutput("cbz1_strobes",      strobes(),        16'b00010);
        checkOutput("cbz1_pcsrc",        16'(pc_source),   16'd1);
        tick();
        checkOutput("cbz1_done_state",   16'(state),       16'd0);

        // CBZ not taken (zero=0).
        applyStimulus(1'b0, OP_CBZ, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("cbz0_state",        16'(state),       16'd8);
        checkOutput("cbz0_aluop",        aluOp(),          16'd1);
        checkOutput("cbz0_r2l",          16'(reg2loc),     16'd1);
        checkOutput("cbz0_strobes",      strobes(),        16'b00000);
        tick();
        checkOutput("cbz0_done_state",   16'(state),       16'd0);

        // Unconditional branch.
        applyStimulus(1'b0, OP_B, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("b_state",           16'(state),       16'd9);
        checkOutput("b_strobes",         strobes(),        16'b00010);
        checkOutput("b_pcsrc",           16'(pc_source),   16'd2);
        tick();
        checkOutput("b_done_state",      16'(state),       16'd0);

        // STUR, then reset while MEM_WR is still waiting.
        applyStimulus(1'b0, OP_STUR, 1'b0, 1'b1);
        tick();
        checkOutput("st_decode_r2l",     16'(reg2loc),     16'd1);
        tick();
        checkOutput("st_addr_state",     16'(state),       16'd3);
        applyStimulus(1'b0, OP_STUR, 1'b0, 1'b0);
        tick();
        checkOutput("st_memwr_state",    16'(state),       16'd6);
        checkOutput("st_memwr_strobes",  strobes(),        16'b01000);
        checkOutput("st_memwr_iord",     16'(i_or_d),      16'd1);
        applyStimulus(1'b1, OP_STUR, 1'b0, 1'b0);
        checkOutput("st_rst_strobes",    strobes(),        16'b00000);
        tick();
        checkOutput("st_rst_state",      16'(state),       16'd0);

        // Fetch timeout: with MAX_WAIT=4, the fourth stalled cycle halts.
        applyStimulus(1'b0, OP_ADD, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("to_fetch_hold", 16'(state),       16'd0);
        end
        checkOutput("to_pre_buserr",     16'(bus_error),   16'd0);
        tick();
        checkOutput("to_halt_state",     16'(state),       16'd15);
        checkOutput("to_halt_buserr",    16'(bus_error),   16'd1);
        checkOutput("to_halt_illegal",   16'(illegal_op),  16'd0);
        checkOutput("to_halt_strobes",   strobes(),        16'b00000);
        applyStimulus(1'b1, OP_ADD, 1'b0, 1'b0);
        tick();
        checkOutput("to_rst_state",      16'(state),       16'd0);
        checkOutput("to_rst_buserr",     16'(bus_error),   16'd0);

        // mem_ready arriving on the last allowed cycle completes normally.
        applyStimulus(1'b0, OP_ADD, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("late_fetch_state",  16'(state),       16'd0);
        applyStimulus(1'b0, OP_ADD, 1'b0, 1'b1);
        checkOutput("late_fetch_strobes", strobes(),       16'b10110);
        tick();
        checkOutput("late_decode_state", 16'(state),       16'd1);
        checkOutput("late_buserr",       16'(bus_error),   16'd0);
        tick();
        tick();
        tick();
        checkOutput("late_done_state",   16'(state),       16'd0);

        // Illegal opcode halts, and the flag holds until reset.
        applyStimulus(1'b0, OP_BAD, 1'b0, 1'b1);
        tick();
        checkOutput("ill_decode_state",  16'(state),       16'd1);
        tick();
        checkOutput("ill_halt_state",    16'(state),       16'd15);
        checkOutput("ill_flag",          16'(illegal_op),  16'd1);
        checkOutput("ill_strobes",       strobes(),        16'b00000);
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput("ill_hold_flag",  16'(illegal_op), 16'd1);
            checkOutput("ill_hold_state", 16'(state),      16'd15);
        end
        applyStimulus(1'b1, OP_ADD, 1'b0, 1'b1);
        tick();
        checkOutput("ill_rst_state",     16'(state),       16'd0);
        checkOutput("ill_rst_flag",      16'(illegal_op),  16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
